// File: rtl/nv_clkgate_pkg.sv
// Shared types and defaults for the NVDLA clock-gate enable controller.
package nv_clkgate_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    GATED = 2'd2,
    WAKE  = 2'd3
  } state_e;

  localparam int unsigned DEF_CNT_W       = 8;
  localparam int unsigned DEF_WAKE_CYCLES = 2;
  localparam int unsigned DEF_STAT_W      = 32;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nv_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module nv_sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/nv_clkgate_en_ctrl.sv
// Idle-detect controller producing E/TE for a latch-based clock-gate cell.
// clk_en is taken straight from a flop so the gate cell never sees a glitch.
module nv_clkgate_en_ctrl
  import nv_clkgate_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned WAKE_CYCLES = DEF_WAKE_CYCLES,
  parameter int unsigned STAT_W      = DEF_STAT_W
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rst,
  input  logic              busy,
  input  logic              wake_req,
  output logic              wake_ack,
  input  logic              cfg_gate_en,
  input  logic [CNT_W-1:0]  cfg_idle_hold,
  input  logic              test_mode,
  output logic              clk_en,
  output logic              clk_te,
  output logic              gated,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] gated_cycles
);

  localparam int unsigned       WAKE_W    = cnt_width(WAKE_CYCLES);
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

  state_e            state_q;
  state_e            state_d;
  logic              clk_en_q;
  logic              wake_ack_q;
  logic              gated_q;
  logic [WAKE_W-1:0] wake_cnt_q;
  logic [CNT_W-1:0]  idle_cnt;
  logic              wake;
  logic              idle_expired;
  logic              idle_inc;
  logic              idle_clr;

  assign wake         = busy | wake_req | ~cfg_gate_en;
  assign idle_expired = (idle_cnt >= cfg_idle_hold);

  // The idle counter sits at zero outside DRAIN, so every DRAIN entry starts a fresh count.
  assign idle_clr = (state_q != DRAIN);
  assign idle_inc = (state_q == DRAIN) && !wake && !idle_expired;

  nv_sat_counter #(
    .WIDTH (CNT_W)
  ) u_idle_cnt (
    .clk_i   (nvdla_core_clk),
    .rst_i   (nvdla_core_rst),
    .clr_i   (idle_clr),
    .inc_i   (idle_inc),
    .count_o (idle_cnt)
  );

  nv_sat_counter #(
    .WIDTH (STAT_W)
  ) u_gated_cnt (
    .clk_i   (nvdla_core_clk),
    .rst_i   (nvdla_core_rst),
    .clr_i   (stat_clr),
    .inc_i   (~clk_en_q),
    .count_o (gated_cycles)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (!wake) state_d = DRAIN;
      end
      DRAIN: begin
        if (wake) begin
          state_d = RUN;
        end else if (idle_expired) begin
          state_d = GATED;
        end
      end
      GATED: begin
        if (wake) state_d = WAKE;
      end
      WAKE: begin
        if (wake_cnt_q == WAKE_LAST) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state_q    <= RUN;
      clk_en_q   <= 1'b1;
      wake_ack_q <= 1'b0;
      gated_q    <= 1'b0;
      wake_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      clk_en_q   <= (state_d != GATED);
      gated_q    <= (state_d == GATED);
      wake_ack_q <= (state_d == RUN) && wake_req;
      if ((state_q == WAKE) && (state_d == WAKE)) begin
        wake_cnt_q <= wake_cnt_q + 1'b1;
      end else begin
        wake_cnt_q <= '0;
      end
    end
  end

  assign clk_en   = clk_en_q;
  assign gated    = gated_q;
  assign wake_ack = wake_ack_q;
  assign clk_te   = test_mode;

endmodule
